ps2_mouse_packet_decoder: RTL and testbench

Assembles the 3-byte PS/2 mouse movement packet from the PS/2 byte receiver into the signed 9-bit X/Y velocities, button state and a one-cycle packet strobe consumed by the mouse position tracker. It is the producer side of the tracker's velocity/enable interface. It sits between the PS/2 byte receiver and the position tracker, and also feeds button state to the sand-placement logic. Byte-0 sync checking, overflow saturation and an inter-byte timeout keep it aligned after glitches or hot-plug.

---
 rtl/ps2_mouse_pkg.sv | 25 ++
 rtl/ps2_mouse_packet_decoder_axis.sv | 20 ++
 rtl/ps2_mouse_packet_decoder.sv | 162 ++++++++++++++++
 tb/tb_ps2_mouse_packet_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
// State encoding, status-byte bit indices, saturation limits.
package ps2_mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2
  } state_t;

  localparam int BTN_L    = 0;
  localparam int BTN_R    = 1;
  localparam int BTN_M    = 2;
  localparam int SYNC_BIT = 3;
  localparam int X_SIGN   = 4;
  localparam int Y_SIGN   = 5;
  localparam int X_OVF    = 6;
  localparam int Y_OVF    = 7;

  localparam int PACKET_BYTES = 3;

  localparam logic [8:0] VEL_POS_MAX = 9'h0FF;
  localparam logic [8:0] VEL_NEG_MAX = 9'h100;

endpackage

// File: rtl/ps2_mouse_packet_decoder_axis.sv
// ps2_axis_decode: combinational map of (sign, overflow, data) to a
// signed 9-bit velocity. Ports: sign, ovf, data[7:0] in; vel[8:0] out.
module ps2_axis_decode
  import ps2_mouse_pkg::*;
(
  input  logic       sign,
  input  logic       ovf,
  input  logic [7:0] data,
  output logic [8:0] vel
);

  // Overflow ignores the data byte and clamps to the signed 9-bit range.
  always_comb begin
    vel = {sign, data};
    if (ovf) begin
      vel = sign ? VEL_NEG_MAX : VEL_POS_MAX;
    end
  end

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// ps2_mouse_packet_decoder: assembles 3-byte PS/2 mouse packets into
// X/Y velocities, buttons and a packet strobe.
// Ports: clk_i, reset_i (async, high), rx_data_i[7:0], rx_done_tick_i in;
// x_velocity_o[8:0], y_velocity_o[8:0], buttons_o[2:0], packet_valid_o,
// sync_error_o, timeout_o out.
module ps2_mouse_packet_decoder
  import ps2_mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 250_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_tick_i,
  output logic [8:0] x_velocity_o,
  output logic [8:0] y_velocity_o,
  output logic [2:0] buttons_o,
  output logic       packet_valid_o,
  output logic       sync_error_o,
  output logic       timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          expire;

  // Status byte fields kept from byte 0 (sync bit is checked, not kept).
  logic [2:0] btn_q,  btn_d;
  logic [1:0] sign_q, sign_d;
  logic [1:0] ovf_q,  ovf_d;
  logic [7:0] xdat_q, xdat_d;

  logic       load;
  logic       pv_d, se_d, to_d;
  logic [8:0] x_vel, y_vel;

  ps2_axis_decode u_x (
    .sign (sign_q[0]),
    .ovf  (ovf_q[0]),
    .data (xdat_q),
    .vel  (x_vel)
  );

  // Byte 2 is decoded straight from the receiver on its tick.
  ps2_axis_decode u_y (
    .sign (sign_q[1]),
    .ovf  (ovf_q[1]),
    .data (rx_data_i),
    .vel  (y_vel)
  );

  assign cnt_inc = cnt_q + CW'(1);
  // Expiry means this idle cycle would bring the count to the limit.
  assign expire  = (cnt_inc == CNT_LIMIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    xdat_d  = xdat_q;
    load    = 1'b0;
    pv_d    = 1'b0;
    se_d    = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      WAIT_B0: begin
        cnt_d = '0;
        if (rx_done_tick_i) begin
          if (rx_data_i[SYNC_BIT]) begin
            btn_d   = {rx_data_i[BTN_M],
                       rx_data_i[BTN_R],
                       rx_data_i[BTN_L]};
            sign_d  = {rx_data_i[Y_SIGN],
                       rx_data_i[X_SIGN]};
            ovf_d   = {rx_data_i[Y_OVF],
                       rx_data_i[X_OVF]};
            state_d = WAIT_B1;
          end else begin
            se_d = 1'b1;
          end
        end
      end
      WAIT_B1: begin
        if (rx_done_tick_i) begin
          xdat_d  = rx_data_i;
          cnt_d   = '0;
          state_d = WAIT_B2;
        end else if (expire) begin
          cnt_d   = '0;
          to_d    = 1'b1;
          state_d = WAIT_B0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_B2: begin
        if (rx_done_tick_i) begin
          load    = 1'b1;
          pv_d    = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_B0;
        end else if (expire) begin
          cnt_d   = '0;
          to_d    = 1'b1;
          state_d = WAIT_B0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = WAIT_B0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= WAIT_B0;
      cnt_q   <= '0;
      btn_q   <= '0;
      sign_q  <= '0;
      ovf_q   <= '0;
      xdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      xdat_q  <= xdat_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_velocity_o   <= '0;
      y_velocity_o   <= '0;
      buttons_o      <= '0;
      packet_valid_o <= 1'b0;
      sync_error_o   <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      packet_valid_o <= pv_d;
      sync_error_o   <= se_d;
      timeout_o      <= to_d;
      if (load) begin
        x_velocity_o <= x_vel;
        y_velocity_o <= y_vel;
        buttons_o    <= btn_q;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Self-checking bench for ps2_mouse_packet_decoder.
// Directed packets, scoreboard of expected packets, pulse counters.
module tb_ps2_mouse_packet_decoder;

  localparam int TO = 16;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] rx_data_i = '0;
  logic       rx_done_tick_i = 1'b0;
  logic [8:0] x_velocity_o;
  logic [8:0] y_velocity_o;
  logic [2:0] buttons_o;
  logic       packet_valid_o;
  logic       sync_error_o;
  logic       timeout_o;

  ps2_mouse_packet_decoder #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .rx_data_i      (rx_data_i),
    .rx_done_tick_i (rx_done_tick_i),
    .x_velocity_o   (x_velocity_o),
    .y_velocity_o   (y_velocity_o),
    .buttons_o      (buttons_o),
    .packet_valid_o (packet_valid_o),
    .sync_error_o   (sync_error_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] b;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_sync = 0;
  int n_to = 0;
  int last_to_cyc = 0;
  logic [8:0] lx = '0;
  logic [8:0] ly = '0;
  logic [2:0] lb = '0;
  logic [7:0] b0_s, b1_s;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] axis(input logic sg,
                                      input logic ov,
                                      input logic [7:0] d);
    int v;
    if (ov) v = sg ? -256 : 255;
    else    v = sg ? int'(d) - 256 : int'(d);
    return v[8:0];
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (packet_valid_o) begin
        chk("pv_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("pv_latency", cyc, e.cyc);
          chk("x_velocity", 32'(x_velocity_o), 32'(e.x));
          chk("y_velocity", 32'(y_velocity_o), 32'(e.y));
          chk("buttons", 32'(buttons_o), 32'(e.b));
        end
      end
      if (sync_error_o) n_sync++;
      if (timeout_o) begin
        n_to++;
        last_to_cyc = cyc;
      end
    end
  end

  task automatic send(input logic [7:0] b, input int pre,
                      input int pos, output int tcyc);
    repeat (pre) @(negedge clk_i);
    rx_data_i = b;
    rx_done_tick_i = 1'b1;
    tcyc = cyc;
    if (pos == 0) b0_s = b;
    if (pos == 1) b1_s = b;
    if (pos == 2) begin
      exp_t e;
      e.x = axis(b0_s[4], b0_s[6], b1_s);
      e.y = axis(b0_s[5], b0_s[7], b);
      e.b = {b0_s[2], b0_s[1], b0_s[0]};
      e.cyc = cyc + 1;
      sb.push_back(e);
      lx = e.x;
      ly = e.y;
      lb = e.b;
    end
    @(negedge clk_i);
    rx_done_tick_i = 1'b0;
    rx_data_i = '0;
  endtask

  task automatic packet(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input int gap);
    int t;
    send(a, gap, 0, t);
    send(b, gap, 1, t);
    send(c, gap, 2, t);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, 32'(x_velocity_o), 0);
    chk({tag, "_y"}, 32'(y_velocity_o), 0);
    chk({tag, "_btn"}, 32'(buttons_o), 0);
    chk({tag, "_strobes"},
        32'({packet_valid_o, sync_error_o, timeout_o}), 0);
  endtask

  initial begin
    int t;
    int s0;
    int t0;
    int k;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk_zero("reset");
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Basic packet (gaps kept below the 16-cycle timeout)
    packet(8'h09, 8'h05, 8'hFB, 12);
    chk("basic_x_hold", 32'(x_velocity_o), 32'h005);

    // Resync on a byte without the sync bit
    s0 = n_sync;
    send(8'h00, 2, 3, t);
    @(negedge clk_i);
    chk("sync_err_cnt", n_sync - s0, 1);
    packet(8'h08, 8'h01, 8'h02, 2);
    chk("sync_err_once", n_sync - s0, 1);

    // Overflow saturation
    packet(8'h58, 8'h10, 8'h00, 2);
    packet(8'h48, 8'h00, 8'h00, 2);

    // Back-to-back ticks, negative X
    packet(8'h19, 8'h80, 8'h7F, 0);

    // Timeout after byte 1
    t0 = n_to;
    send(8'h08, 2, 0, t);
    send(8'h03, 2, 1, t);
    k = 0;
    while (n_to == t0 && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    chk("timeout_seen", n_to - t0, 1);
    chk("timeout_lat", last_to_cyc - t, 17);
    repeat (2) @(negedge clk_i);
    chk("timeout_once", n_to - t0, 1);
    chk("to_hold_x", 32'(x_velocity_o), 32'(lx));
    chk("to_hold_y", 32'(y_velocity_o), 32'(ly));
    chk("to_hold_b", 32'(buttons_o), 32'(lb));
    packet(8'h08, 8'h04, 8'h05, 2);

    // Ticks exactly on the expiry cycle
    t0 = n_to;
    send(8'h0C, 2, 0, t);
    s0 = t;
    send(8'h07, TO - 1, 1, t);
    chk("expiry_gap_b1", t - s0, TO);
    s0 = t;
    send(8'h01, TO - 1, 2, t);
    chk("expiry_gap_b2", t - s0, TO);
    repeat (3) @(negedge clk_i);
    chk("expiry_no_to", n_to - t0, 0);

    // Reset mid-packet
    send(8'h09, 2, 0, t);
    send(8'h05, 2, 1, t);
    #1 reset_i = 1'b1;
    #1 chk_zero("mid_rst_a");
    lx = '0;
    ly = '0;
    lb = '0;
    repeat (2) @(negedge clk_i);
    chk_zero("mid_rst_b");
    reset_i = 1'b0;
    packet(8'h0A, 8'h01, 8'h01, 2);

    repeat (5) @(negedge clk_i);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
